pq_drain_sequencer: RTL and testbench

//  Read-side initiator for the min-priority queue: issues dequeue pulses to the PQ, captures each
//  (data, tag) response, and streams it downstream in ascending-tag order on a ready/valid interface.

---
 rtl/pq_drain_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pq_drain_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_drain_sequencer.sv
// Drains the min-priority queue in tag order into a small skid FIFO feeding a ready/valid stream.
// A drain stops on count, empty, over-limit tag (element spilled for re-enqueue) or abort.
module pq_drain_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 32,
   parameter int PQ_DEPTH   = 8,
   parameter int BUF_DEPTH  = 4,
   localparam int CNT_WIDTH = $clog2(PQ_DEPTH) + 1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic [CNT_WIDTH-1:0]  count_in,
   input  logic [TAG_WIDTH-1:0]  limit_tag_in,
   input  logic                  abort_in,
   output logic                  pq_deq_out,
   input  logic                  pq_empty_in,
   input  logic                  pq_valid_in,
   input  logic [DATA_WIDTH-1:0] pq_data_in,
   input  logic [TAG_WIDTH-1:0]  pq_tag_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [TAG_WIDTH-1:0]  tag_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  spill_valid_out,
   output logic [DATA_WIDTH-1:0] spill_data_out,
   output logic [TAG_WIDTH-1:0]  spill_tag_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [1:0]            reason_out,
   output logic [CNT_WIDTH-1:0]  drained_out
);

   localparam int PTR_WIDTH  = $clog2(BUF_DEPTH);
   localparam int FCNT_WIDTH = PTR_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = CNT_WIDTH'(PQ_DEPTH);
   localparam logic [FCNT_WIDTH:0]   BUF_LIMIT = (FCNT_WIDTH + 1)'(BUF_DEPTH);
   localparam logic [1:0] REASON_COUNT = 2'd0;
   localparam logic [1:0] REASON_EMPTY = 2'd1;
   localparam logic [1:0] REASON_LIMIT = 2'd2;
   localparam logic [1:0] REASON_ABORT = 2'd3;

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

   state_t                 state;
   logic [CNT_WIDTH-1:0]   count_q;
   logic [CNT_WIDTH-1:0]   issued;
   logic [TAG_WIDTH-1:0]   limit_q;
   logic                   inflight;
   logic [DATA_WIDTH-1:0]  mem_data [BUF_DEPTH];
   logic [TAG_WIDTH-1:0]   mem_tag [BUF_DEPTH];
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [FCNT_WIDTH-1:0]  fifo_count;

   logic                   in_drain;
   logic                   over_limit;
   logic                   count_ok;
   logic                   room_ok;
   logic [FCNT_WIDTH:0]    occupancy;
   logic                   resp_ok;
   logic                   resp_over;
   logic                   resp_drop;
   logic                   pop;
   logic                   stop_count;
   logic                   stop_empty;

   assign in_drain   = (state == DRAIN);
   assign over_limit = (pq_tag_in > limit_q);
   assign count_ok   = (count_q == '0) || (issued < count_q);
   // Reserve a FIFO slot for every outstanding request so a response can always be absorbed
   assign occupancy  = {1'b0, fifo_count} + {{FCNT_WIDTH{1'b0}}, inflight};
   assign room_ok    = (occupancy < BUF_LIMIT);

   assign pq_deq_out = in_drain && !pq_empty_in && count_ok && room_ok
                       && !(pq_valid_in && over_limit) && !abort_in;

   assign resp_ok    = in_drain && inflight && pq_valid_in && !over_limit && !abort_in;
   assign resp_over  = in_drain && inflight && pq_valid_in && over_limit && !abort_in;
   assign resp_drop  = inflight && !pq_valid_in;
   assign stop_count = (count_q != '0) && (issued == count_q) && !inflight;
   assign stop_empty = pq_empty_in && !inflight && !pq_deq_out;

   assign valid_out  = (fifo_count != '0);
   assign data_out   = mem_data[rd_ptr];
   assign tag_out    = mem_tag[rd_ptr];
   assign pop        = valid_out && ready_in;
   assign busy_out   = (state != IDLE);
   assign done_out   = (state == DONE);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= IDLE;
         count_q         <= '0;
         issued          <= '0;
         limit_q         <= '0;
         inflight        <= 1'b0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         fifo_count      <= '0;
         spill_valid_out <= 1'b0;
         spill_data_out  <= '0;
         spill_tag_out   <= '0;
         reason_out      <= '0;
         drained_out     <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_tag[i]  <= '0;
         end
      end else begin
         inflight <= pq_deq_out;
         if (resp_ok) begin
            mem_data[wr_ptr] <= pq_data_in;
            mem_tag[wr_ptr]  <= pq_tag_in;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (drained_out != CNT_MAX) drained_out <= drained_out + 1'b1;
         end
         fifo_count <= fifo_count + FCNT_WIDTH'(resp_ok) - FCNT_WIDTH'(pop);

         // A request whose response never arrived no longer counts against the drain count
         if (pq_deq_out && !resp_drop) begin
            if (issued != CNT_MAX) issued <= issued + 1'b1;
         end else if (resp_drop && !pq_deq_out) begin
            if (issued != '0) issued <= issued - 1'b1;
         end

         case (state)
            IDLE: begin
               if (start_in) begin
                  state           <= DRAIN;
                  count_q         <= count_in;
                  limit_q         <= limit_tag_in;
                  issued          <= '0;
                  drained_out     <= '0;
                  spill_valid_out <= 1'b0;
               end
            end
            DRAIN: begin
               if (abort_in) begin
                  state      <= DONE;
                  reason_out <= REASON_ABORT;
                  rd_ptr     <= '0;
                  wr_ptr     <= '0;
                  fifo_count <= '0;
               end else if (resp_over) begin
                  state           <= FLUSH;
                  reason_out      <= REASON_LIMIT;
                  spill_valid_out <= 1'b1;
                  spill_data_out  <= pq_data_in;
                  spill_tag_out   <= pq_tag_in;
               end else if (stop_count) begin
                  state      <= FLUSH;
                  reason_out <= REASON_COUNT;
               end else if (stop_empty) begin
                  state      <= FLUSH;
                  reason_out <= REASON_EMPTY;
               end
            end
            FLUSH: begin
               if (abort_in) begin
                  state      <= DONE;
                  reason_out <= REASON_ABORT;
                  rd_ptr     <= '0;
                  wr_ptr     <= '0;
                  fifo_count <= '0;
               end else if (fifo_count == '0) begin
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pq_drain_sequencer.sv
// Scoreboard bench for pq_drain_sequencer: a queue-based PQ stand-in feeds the DUT and a
// sorted-list reference predicts each drain's stream, spill, reason and leftover PQ size.
module tb_pq_drain_sequencer;

   typedef struct packed {
      logic [31:0] tag;
      logic [31:0] data;
   } elem_t;

   typedef struct packed {
      logic [1:0]  reason;
      logic [31:0] drained;
      logic        spill_v;
      elem_t       spill;
   } done_t;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        start_in;
   logic [3:0]  count_in;
   logic [31:0] limit_tag_in;
   logic        abort_in;
   logic        pq_deq_out;
   logic        pq_empty_in;
   logic        pq_valid_in;
   logic [31:0] pq_data_in;
   logic [31:0] pq_tag_in;
   logic [31:0] data_out;
   logic [31:0] tag_out;
   logic        valid_out;
   logic        ready_in;
   logic        spill_valid_out;
   logic [31:0] spill_data_out;
   logic [31:0] spill_tag_out;
   logic        busy_out;
   logic        done_out;
   logic [1:0]  reason_out;
   logic [3:0]  drained_out;

   int errors = 0;
   int checks = 0;

   elem_t stim_q[$];
   elem_t stage_q[$];
   elem_t pq_q[$];
   elem_t exp_q[$];
   done_t done_q[$];
   int    clear_req = 0;
   int    deq_total = 0;
   int    pq_size = 0;
   int    uid = 0;

   pq_drain_sequencer dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .count_in(count_in),
      .limit_tag_in(limit_tag_in), .abort_in(abort_in), .pq_deq_out(pq_deq_out),
      .pq_empty_in(pq_empty_in), .pq_valid_in(pq_valid_in), .pq_data_in(pq_data_in),
      .pq_tag_in(pq_tag_in), .data_out(data_out), .tag_out(tag_out), .valid_out(valid_out),
      .ready_in(ready_in), .spill_valid_out(spill_valid_out), .spill_data_out(spill_data_out),
      .spill_tag_out(spill_tag_out), .busy_out(busy_out), .done_out(done_out),
      .reason_out(reason_out), .drained_out(drained_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // PQ stand-in: pops the smallest tag (earliest insert on ties), answers one cycle later
   initial begin : pq_model
      int    stage_rd;
      int    clear_seen;
      int    idx;
      logic  got;
      elem_t resp;
      stage_rd = 0;
      clear_seen = 0;
      resp = '0;
      pq_valid_in = 1'b0;
      pq_data_in = '0;
      pq_tag_in = '0;
      pq_empty_in = 1'b1;
      forever begin
         @(negedge clk_in);
         got = 1'b0;
         if (pq_deq_out) begin
            deq_total++;
            if (pq_q.size() > 0) begin
               idx = 0;
               for (int i = 1; i < pq_q.size(); i++)
                  if (pq_q[i].tag < pq_q[idx].tag) idx = i;
               resp = pq_q[idx];
               pq_q.delete(idx);
               got = 1'b1;
            end
         end
         @(posedge clk_in);
         #2;
         if (clear_seen != clear_req) begin
            pq_q.delete();
            clear_seen = clear_req;
         end
         while (stage_rd < stage_q.size()) begin
            pq_q.push_back(stage_q[stage_rd]);
            stage_rd++;
         end
         pq_valid_in = got;
         pq_data_in  = got ? resp.data : 32'h0;
         pq_tag_in   = got ? resp.tag : 32'h0;
         pq_empty_in = (pq_q.size() == 0);
         pq_size     = pq_q.size();
      end
   end

   initial begin : monitor
      logic        prev_stall;
      logic [63:0] prev_val;
      elem_t       e;
      done_t       d;
      prev_stall = 1'b0;
      prev_val = '0;
      forever begin
         @(negedge clk_in);
         if (rst_in) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall)
            checkOutput("hold_stable", {valid_out, tag_out, data_out}, {1'b1, prev_val});
         prev_stall = valid_out && !ready_in && !abort_in;
         prev_val = {tag_out, data_out};
         if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_xfer", {tag_out, data_out}, 128'h0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("stream_elem", {tag_out, data_out}, {e.tag, e.data});
            end
         end
         if (done_out) begin
            if (done_q.size() == 0) begin
               checkOutput("unexpected_done", 128'(done_out), 128'h0);
            end else begin
               d = done_q.pop_front();
               checkOutput("done_reason", 128'(reason_out), 128'(d.reason));
               checkOutput("done_drained", 128'(drained_out), 128'(d.drained));
               checkOutput("spill_valid", 128'(spill_valid_out), 128'(d.spill_v));
               if (d.spill_v)
                  checkOutput("spill_elem", {spill_tag_out, spill_data_out},
                              {d.spill.tag, d.spill.data});
            end
         end
      end
   end

   task automatic addElem(input int tag);
      uid++;
      stim_q.push_back({32'(tag), 32'hD000_0000 | 32'(uid)});
   endtask

   task automatic checkIdleOutputs(input string pfx);
      checkOutput({pfx, "_deq"}, 128'(pq_deq_out), 128'h0);
      checkOutput({pfx, "_valid"}, 128'(valid_out), 128'h0);
      checkOutput({pfx, "_stream"}, {tag_out, data_out}, 128'h0);
      checkOutput({pfx, "_spill"}, {spill_valid_out, spill_tag_out, spill_data_out}, 128'h0);
      checkOutput({pfx, "_busy_done"}, {busy_out, done_out}, 128'h0);
      checkOutput({pfx, "_reason"}, 128'(reason_out), 128'h0);
      checkOutput({pfx, "_drained"}, 128'(drained_out), 128'h0);
   endtask

   task automatic clearPq();
      stim_q.delete();
      clear_req++;
      @(posedge clk_in);
      #1;
   endtask

   task automatic loadAndStart(input int cnt, input logic [31:0] lim, input logic rdy);
      foreach (stim_q[i]) stage_q.push_back(stim_q[i]);
      @(posedge clk_in);
      #1;
      count_in = 4'(cnt);
      limit_tag_in = lim;
      ready_in = rdy;
      start_in = 1'b1;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
   endtask

   // mode 0: ready high, 1: random ready, 2: ready low for 10 cycles then high
   task automatic applyStimulus(input int cnt, input logic [31:0] lim, input int mode,
                                output int cycles);
      elem_t sorted[$];
      int    pos;
      int    take;
      int    streamed;
      int    d0;
      int    exp_rem;
      done_t d;
      sorted.delete();
      foreach (stim_q[i]) begin
         pos = sorted.size();
         while (pos > 0 && sorted[pos-1].tag > stim_q[i].tag) pos--;
         sorted.insert(pos, stim_q[i]);
      end
      take = (cnt == 0 || cnt > sorted.size()) ? sorted.size() : cnt;
      streamed = 0;
      d = '0;
      for (int i = 0; i < take; i++) begin
         if (sorted[i].tag > lim) begin
            d.spill_v = 1'b1;
            d.spill = sorted[i];
            break;
         end
         exp_q.push_back(sorted[i]);
         streamed++;
      end
      if (d.spill_v) d.reason = 2'd2;
      else if (cnt != 0 && cnt <= sorted.size()) d.reason = 2'd0;
      else d.reason = 2'd1;
      d.drained = 32'(streamed);
      done_q.push_back(d);
      exp_rem = sorted.size() - streamed - (d.spill_v ? 1 : 0);

      loadAndStart(cnt, lim, mode != 2);
      d0 = deq_total;
      cycles = 0;
      while (!done_out && cycles < 400) begin
         case (mode)
            0:       ready_in = 1'b1;
            1:       ready_in = ($urandom_range(0, 3) != 0);
            default: ready_in = (cycles >= 10);
         endcase
         if (mode == 2 && cycles == 10)
            checkOutput("stall_pops", 128'(deq_total - d0),
                        128'((streamed + (d.spill_v ? 1 : 0)) < 4 ?
                             (streamed + (d.spill_v ? 1 : 0)) : 4));
         @(posedge clk_in);
         #1;
         cycles++;
      end
      if (!done_out) begin
         checkOutput("done_timeout", 128'(done_out), 128'h1);
         exp_q.delete();
         done_q.delete();
         rst_in = 1'b1;
         @(posedge clk_in);
         #1;
         rst_in = 1'b0;
      end
      ready_in = 1'b1;
      @(posedge clk_in);
      #3;
      checkOutput("pq_remaining", 128'(pq_size), 128'(exp_rem));
      checkOutput("stream_left", 128'(exp_q.size()), 128'h0);
      checkOutput("done_left", 128'(done_q.size()), 128'h0);
      clearPq();
   endtask

   initial begin : main
      int cyc;
      int d0;
      done_t d;
      rst_in = 1'b1;
      start_in = 1'b0;
      count_in = '0;
      limit_tag_in = '1;
      abort_in = 1'b0;
      ready_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      checkIdleOutputs("reset");

      // T1: unbounded drain of {7,3,9,1}
      addElem(7); addElem(3); addElem(9); addElem(1);
      applyStimulus(0, '1, 0, cyc);

      // T2: count-limited
      addElem(7); addElem(3); addElem(9); addElem(1);
      applyStimulus(2, '1, 0, cyc);

      // T3: tag limit 5 spills the 7
      addElem(7); addElem(3); addElem(9); addElem(1);
      applyStimulus(0, 32'd5, 0, cyc);

      // T4: full PQ under back-pressure
      for (int i = 0; i < 8; i++) addElem(80 - 3 * i);
      applyStimulus(0, '1, 2, cyc);

      // Count equal to PQ depth
      for (int i = 0; i < 8; i++) addElem(i * 5 % 7);
      applyStimulus(8, '1, 1, cyc);

      // T5: abort one cycle after the first valid_out
      addElem(4); addElem(2); addElem(8); addElem(6); addElem(5);
      loadAndStart(0, '1, 1'b0);
      cyc = 0;
      while (!valid_out && cyc < 20) begin
         @(posedge clk_in);
         #1;
         cyc++;
      end
      checkOutput("t5_first_valid", 128'(valid_out), 128'h1);
      @(posedge clk_in);
      #1;
      abort_in = 1'b1;
      d = '0;
      d.reason = 2'd3;
      done_q.push_back(d);
      @(posedge clk_in);
      #1;
      abort_in = 1'b0;
      d0 = deq_total;
      checkOutput("t5_valid_drop", 128'(valid_out), 128'h0);
      checkOutput("t5_done", 128'(done_out), 128'h1);
      repeat (5) @(posedge clk_in);
      #1;
      checkOutput("t5_no_deq", 128'(deq_total), 128'(d0));
      checkOutput("t5_done_left", 128'(done_q.size()), 128'h0);
      ready_in = 1'b1;
      clearPq();

      // T6: start on an empty PQ
      d0 = deq_total;
      applyStimulus(0, '1, 0, cyc);
      checkOutput("t6_done_latency", 128'(cyc), 128'd2);
      checkOutput("t6_no_deq", 128'(deq_total), 128'(d0));

      // Reset in the middle of a stalled drain
      addElem(10); addElem(20); addElem(30); addElem(40); addElem(50); addElem(60);
      loadAndStart(0, '1, 1'b0);
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      checkIdleOutputs("midrst");
      rst_in = 1'b0;
      ready_in = 1'b1;
      clearPq();
      repeat (2) @(posedge clk_in);
      #1;

      for (int r = 0; r < 12; r++) begin
         int n;
         int cnt;
         logic [31:0] lim;
         n = $urandom_range(0, 8);
         for (int i = 0; i < n; i++) addElem($urandom_range(0, 15));
         cnt = $urandom_range(0, 8);
         lim = ($urandom_range(0, 1) == 1) ? '1 : 32'($urandom_range(0, 15));
         applyStimulus(cnt, lim, $urandom_range(0, 1), cyc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
